// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and constants for the sequential BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int         DIGW     = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_core.sv
// ============================================================================
// Module   : bcd_dabble_core
// Brief    : Single-channel iterative shift-add-3 binary-to-BCD engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dabble_core
    import bcd_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int NDIG  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [WIDTH-1:0]       value,
    input  logic                   step,
    output logic [NDIG*DIGW-1:0]   bcd,
    output logic                   ovf
);

    localparam int DW = NDIG * DIGW;

    logic [DW-1:0]    r_bcd;
    logic [WIDTH-1:0] r_sh;
    logic             r_ovf;
    logic [DW-1:0]    w_adj;

    for (genvar d = 0; d < NDIG; d++) begin : g_adj
        assign w_adj[d*DIGW +: DIGW] = (r_bcd[d*DIGW +: DIGW] >= 4'd5)
                                     ? r_bcd[d*DIGW +: DIGW] + 4'd3
                                     : r_bcd[d*DIGW +: DIGW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd <= '0;
            r_sh  <= '0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_bcd <= '0;
            r_sh  <= value;
            r_ovf <= 1'b0;
        end else if (step) begin
            r_bcd <= {w_adj[DW-2:0], r_sh[WIDTH-1]};
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            // A bit leaving the top digit means the value needs one more digit.
            if (w_adj[DW-1])
                r_ovf <= 1'b1;
        end
    end

    assign bcd = r_bcd;
    assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/bcd_convert_seq.sv
// ============================================================================
// Module   : bcd_convert_seq
// Brief    : Multi-channel clocked binary-to-BCD converter sharing one engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int WIDTH = 10,
    parameter int NDIG  = 4,
    parameter int BLANK = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NCH*WIDTH-1:0]      din,
    output logic                      busy,
    output logic                      done,
    output logic [NCH*NDIG*DIGW-1:0]  bcd,
    output logic [NCH*NDIG-1:0]       blank,
    output logic [NCH-1:0]            ovf
);

    localparam int DW   = NDIG * DIGW;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NBUF = (NCH > 1) ? NCH - 1 : 1;

    state_t                r_state;
    state_t                w_next;
    logic [NCH*WIDTH-1:0]  r_hold;
    logic [CNTW-1:0]       r_cnt;
    logic [CHW-1:0]        r_ch;
    logic                  r_busy;
    logic                  r_done;
    logic [NCH*DW-1:0]     r_bcd;
    logic [NCH*NDIG-1:0]   r_blank;
    logic [NCH-1:0]        r_ovf;
    logic [DW-1:0]         r_buf_bcd [NBUF];
    logic [NBUF-1:0]       r_buf_ovf;

    logic [WIDTH-1:0]      w_value;
    logic                  w_load;
    logic                  w_step;
    logic                  w_last_bit;
    logic                  w_last_ch;
    logic [DW-1:0]         w_core_bcd;
    logic                  w_core_ovf;
    logic [DW-1:0]         w_sat_bcd;
    logic [NCH*DW-1:0]     w_res_bcd;
    logic [NCH-1:0]        w_res_ovf;
    logic [NCH*NDIG-1:0]   w_res_blank;

    assign w_load     = (r_state == ST_LOAD);
    assign w_step     = (r_state == ST_SHIFT);
    assign w_last_bit = (r_cnt == CNTW'(1));
    assign w_last_ch  = (r_ch == CHW'(NCH - 1));
    assign w_sat_bcd  = w_core_ovf ? {NDIG{BCD_NINE}} : w_core_bcd;

    always_comb begin
        w_value = '0;
        for (int c = 0; c < NCH; c++)
            if (r_ch == CHW'(c))
                w_value = r_hold[c*WIDTH +: WIDTH];
    end

    bcd_dabble_core #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .value (w_value),
        .step  (w_step),
        .bcd   (w_core_bcd),
        .ovf   (w_core_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_next = w_last_ch ? ST_DONE : ST_LOAD;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold  <= '0;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_blank <= '0;
            r_ovf   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_hold <= din;
                        r_busy <= 1'b1;
                    end
                end
                ST_LOAD:  r_cnt <= CNTW'(WIDTH);
                ST_SHIFT: begin
                    r_cnt <= r_cnt - CNTW'(1);
                    if (w_last_bit)
                        r_ch <= w_last_ch ? '0 : r_ch + CHW'(1);
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_bcd   <= w_res_bcd;
                    r_blank <= w_res_blank;
                    r_ovf   <= w_res_ovf;
                end
                default: ;
            endcase
        end
    end

    // The engine still holds channel c's result during the LOAD of channel c+1.
    for (genvar c = 0; c < NCH - 1; c++) begin : g_buf
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_buf_bcd[c] <= '0;
                r_buf_ovf[c] <= 1'b0;
            end else if (w_load && (r_ch == CHW'(c + 1))) begin
                r_buf_bcd[c] <= w_sat_bcd;
                r_buf_ovf[c] <= w_core_ovf;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_res
        if (c == NCH - 1) begin : g_live
            assign w_res_bcd[c*DW +: DW] = w_sat_bcd;
            assign w_res_ovf[c]          = w_core_ovf;
        end else begin : g_stored
            assign w_res_bcd[c*DW +: DW] = r_buf_bcd[c];
            assign w_res_ovf[c]          = r_buf_ovf[c];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_blank_ch
        for (genvar d = 0; d < NDIG; d++) begin : g_blank_dig
            if ((BLANK != 0) && (d > 0)) begin : g_on
                assign w_res_blank[c*NDIG + d] =
                    (w_res_bcd[c*DW + d*DIGW +: (NDIG - d)*DIGW] == '0);
            end else begin : g_off
                assign w_res_blank[c*NDIG + d] = 1'b0;
            end
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign bcd   = r_bcd;
    assign blank = r_blank;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bcd_convert_seq.sv
// ============================================================================
// Module   : tb_bcd_convert_seq
// Brief    : Self-checking bench for bcd_convert_seq (NDIG=4 and NDIG=3/BLANK=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_convert_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [19:0] din = '0;

    logic        busy4, done4;
    logic [31:0] bcd4;
    logic [7:0]  blank4;
    logic [1:0]  ovf4;
    logic        busy3, done3;
    logic [23:0] bcd3;
    logic [5:0]  blank3;
    logic [1:0]  ovf3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] e4_bcd;
    logic [7:0]  e4_bl;
    logic [1:0]  e4_ov;
    logic [23:0] e3_bcd;
    logic [5:0]  e3_bl;
    logic [1:0]  e3_ov;

    always #5 clk = ~clk;

    bcd_convert_seq #(.NCH(2), .WIDTH(10), .NDIG(4), .BLANK(1)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .busy(busy4), .done(done4), .bcd(bcd4), .blank(blank4), .ovf(ovf4)
    );

    bcd_convert_seq #(.NCH(2), .WIDTH(10), .NDIG(3), .BLANK(0)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .busy(busy3), .done(done3), .bcd(bcd3), .blank(blank3), .ovf(ovf3)
    );

    // Decimal reference: saturate, then split into digits by division.
    function automatic void model_chan(input int v, input int nd, input bit blk,
                                       output logic [15:0] dg, output logic [3:0] bl,
                                       output logic o);
        int lim, s, p;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        o  = (v >= lim);
        s  = o ? lim - 1 : v;
        dg = '0;
        bl = '0;
        p  = 1;
        for (int d = 0; d < nd; d++) begin
            dg[d*4 +: 4] = 4'((s / p) % 10);
            bl[d]        = blk && (d > 0) && ((s / p) == 0);
            p            = p * 10;
        end
    endfunction

    function automatic void model(input logic [19:0] v);
        logic [15:0] dg;
        logic [3:0]  bl;
        logic        o;
        int          x;
        for (int c = 0; c < 2; c++) begin
            x = v[c*10 +: 10];
            model_chan(x, 4, 1'b1, dg, bl, o);
            e4_bcd[c*16 +: 16] = dg;
            e4_bl[c*4 +: 4]    = bl;
            e4_ov[c]           = o;
            model_chan(x, 3, 1'b0, dg, bl, o);
            e3_bcd[c*12 +: 12] = dg[11:0];
            e3_bl[c*3 +: 3]    = bl[2:0];
            e3_ov[c]           = o;
        end
    endfunction

    task automatic start_conv(input logic [19:0] v);
        din   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles, required within 23", cyc);
        end
    endtask

    task automatic test_reset_init;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy4, done4, bcd4, blank4, ovf4, busy3, done3, bcd3, blank3, ovf3} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b bcd=%h blank=%b ovf=%b, required all 0",
                     busy4, done4, bcd4, blank4, ovf4);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [19:0] vec [3];
        int cyc;
        vec[0] = {10'd1023, 10'd999};
        vec[1] = {10'd7,    10'd0};
        vec[2] = {10'd512,  10'd1023};
        for (int i = 0; i < 3; i++) begin
            model(vec[i]);
            start_conv(vec[i]);
            n_checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_after_start: got busy=%b done=%b, required busy=1 done=0", busy4, done4);
            end
            wait_done(cyc);
            n_checks++;
            if (cyc != 23 || done3 !== 1'b1 || busy4 !== 1'b0) begin
                n_fail++;
                $display("FAIL latency: got %0d cycles (done3=%b busy=%b), required 23 with busy=0", cyc, done3, busy4);
            end
            n_checks++;
            if ({bcd4, blank4, ovf4} !== {e4_bcd, e4_bl, e4_ov}) begin
                n_fail++;
                $display("FAIL result_ndig4 vec%0d: got bcd=%h blank=%b ovf=%b, required bcd=%h blank=%b ovf=%b",
                         i, bcd4, blank4, ovf4, e4_bcd, e4_bl, e4_ov);
            end
            n_checks++;
            if ({bcd3, blank3, ovf3} !== {e3_bcd, e3_bl, e3_ov}) begin
                n_fail++;
                $display("FAIL result_ndig3 vec%0d: got bcd=%h blank=%b ovf=%b, required bcd=%h blank=%b ovf=%b",
                         i, bcd3, blank3, ovf3, e3_bcd, e3_bl, e3_ov);
            end
            @(negedge clk);
            n_checks++;
            if (done4 !== 1'b0 || busy4 !== 1'b0 || {bcd4, blank4, ovf4} !== {e4_bcd, e4_bl, e4_ov}) begin
                n_fail++;
                $display("FAIL done_pulse: got done=%b busy=%b bcd=%h, required done=0 busy=0 bcd=%h",
                         done4, busy4, bcd4, e4_bcd);
            end
        end
    endtask

    task automatic test_reset_idle;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy4, done4, bcd4, blank4, ovf4, busy3, done3, bcd3, blank3, ovf3} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_async: got bcd=%h blank=%b ovf=%b busy=%b, required all 0",
                     bcd4, blank4, ovf4, busy4);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random_back_to_back;
        logic [9:0]  bnd [8];
        logic [9:0]  x, y;
        logic [19:0] v;
        int cyc;
        bnd[0] = 10'd0;   bnd[1] = 10'd9;   bnd[2] = 10'd10;   bnd[3] = 10'd99;
        bnd[4] = 10'd100; bnd[5] = 10'd999; bnd[6] = 10'd1000; bnd[7] = 10'd1023;
        for (int i = 0; i < 16; i++) begin
            x = (i % 3 == 0) ? bnd[$urandom_range(0, 7)] : 10'($urandom_range(0, 1023));
            y = (i % 4 == 1) ? bnd[$urandom_range(0, 7)] : 10'($urandom_range(0, 1023));
            v = {y, x};
            model(v);
            start_conv(v);
            wait_done(cyc);
            n_checks++;
            if (cyc != 23) begin
                n_fail++;
                $display("FAIL rand_latency #%0d: got %0d cycles, required 23", i, cyc);
            end
            n_checks++;
            if ({bcd4, blank4, ovf4, bcd3, blank3, ovf3} !==
                {e4_bcd, e4_bl, e4_ov, e3_bcd, e3_bl, e3_ov}) begin
                n_fail++;
                $display("FAIL rand_result #%0d din=%h: got %h/%b/%b %h/%b/%b, required %h/%b/%b %h/%b/%b",
                         i, v, bcd4, blank4, ovf4, bcd3, blank3, ovf3,
                         e4_bcd, e4_bl, e4_ov, e3_bcd, e3_bl, e3_ov);
            end
        end
    endtask

    task automatic test_ignored_start;
        logic [19:0] a, b, c, d;
        logic        held_bad;
        int          cyc;
        a = {10'd321, 10'd45};
        b = {10'd888, 10'd1001};
        c = {10'd1,   10'd2};
        d = {10'd60,  10'd1010};
        start_conv(a);
        wait_done(cyc);
        model(a);
        start_conv(b);
        cyc = 0;
        held_bad = 1'b0;
        while (done4 !== 1'b1 && cyc < 100) begin
            if ({bcd4, blank4, ovf4} !== {e4_bcd, e4_bl, e4_ov}) held_bad = 1'b1;
            if (cyc == 5 || cyc == 22) begin
                din   = c;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (held_bad) begin
            n_fail++;
            $display("FAIL outputs_held: got outputs changing during conversion, required previous %h", e4_bcd);
        end
        model(b);
        n_checks++;
        if (cyc != 23 || {bcd4, blank4, ovf4} !== {e4_bcd, e4_bl, e4_ov}) begin
            n_fail++;
            $display("FAIL ignored_start: got %0d cycles bcd=%h ovf=%b, required 23 cycles bcd=%h ovf=%b",
                     cyc, bcd4, ovf4, e4_bcd, e4_ov);
        end
        model(d);
        start_conv(d);
        wait_done(cyc);
        n_checks++;
        if (cyc != 23 || {bcd4, blank4, ovf4, bcd3, ovf3} !== {e4_bcd, e4_bl, e4_ov, e3_bcd, e3_ov}) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d cycles bcd=%h ovf=%b, required 23 cycles bcd=%h ovf=%b",
                     cyc, bcd4, ovf4, e4_bcd, e4_ov);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [19:0] v;
        logic        saw_done;
        int          cyc;
        start_conv({10'd700, 10'd123});
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy4, done4, bcd4, blank4, ovf4, busy3, done3, bcd3, blank3, ovf3} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b bcd=%h blank=%b ovf=%b, required all 0",
                     busy4, done4, bcd4, blank4, ovf4);
        end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done4 !== 1'b0 || busy4 !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_abort: got done/busy activity after reset, required none");
        end
        v = {10'd46, 10'd1000};
        model(v);
        start_conv(v);
        wait_done(cyc);
        n_checks++;
        if (cyc != 23 || {bcd4, blank4, ovf4, bcd3, blank3, ovf3} !==
            {e4_bcd, e4_bl, e4_ov, e3_bcd, e3_bl, e3_ov}) begin
            n_fail++;
            $display("FAIL after_reset: got %0d cycles bcd=%h blank=%b ovf=%b, required 23 cycles bcd=%h blank=%b ovf=%b",
                     cyc, bcd4, blank4, ovf4, e4_bcd, e4_bl, e4_ov);
        end
    endtask

    initial begin
        test_reset_init();
        test_directed();
        test_reset_idle();
        test_random_back_to_back();
        test_ignored_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
